// File: rtl/mem_master.sv
// Burst read/write initiator for a 512x32 synchronous RAM with a 1-cycle registered read.
// Optional macro MEM_MASTER_BOUNDS_EN rejects bursts that run past the top address and sets a sticky err.
module mem_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BURST_W-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] BusMuxOut,
  input  logic [DATA_W-1:0] MDataIn
);

  typedef enum logic [2:0] {IDLE, RD, RD_DRAIN, WR, FIN} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    ptr;
  logic [BURST_W-1:0]   remaining;
  logic                 rd_inflight;
  logic                 out_of_range;

`ifdef MEM_MASTER_BOUNDS_EN
  logic [ADDR_W:0] end_addr;
  logic            err_q;

  // The carry bit of start+len marks a burst that would cross the top word.
  assign end_addr     = {1'b0, req_addr} + {{(ADDR_W+1-BURST_W){1'b0}}, req_len};
  assign out_of_range = end_addr[ADDR_W];
  assign err          = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (state == IDLE && req_valid && out_of_range)
      err_q <= 1'b1;
  end
`else
  assign out_of_range = 1'b0;
  assign err          = 1'b0;
`endif

  // NOTE: every register here uses <= so all branches see pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      read        <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      BusMuxOut   <= '0;
      ptr         <= '0;
      remaining   <= '0;
      rd_inflight <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      done        <= 1'b0;
    end else begin
      // Two-stage return path: RAM output register, then our response register.
      rd_inflight <= read;
      rsp_valid   <= rd_inflight;
      if (rd_inflight)
        rsp_data <= MDataIn;
      done  <= 1'b0;
      write <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            remaining <= req_len;
            addr      <= req_addr;
            if (out_of_range) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (req_we) begin
              state       <= WR;
              wdata_ready <= 1'b1;
              ptr         <= req_addr;
            end else begin
              state <= RD;
              read  <= 1'b1;
              ptr   <= req_addr + ADDR_W'(1);
            end
          end
        end

        RD: begin
          if (remaining == '0) begin
            read  <= 1'b0;
            state <= RD_DRAIN;
          end else begin
            remaining <= remaining - BURST_W'(1);
            addr      <= ptr;
            ptr       <= ptr + ADDR_W'(1);
          end
        end

        // Last beat is on rsp_valid once nothing is left in the return path.
        RD_DRAIN: begin
          if (rsp_valid && !rd_inflight) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end

        // wdata_ready low inside WR means the final strobe is on the bus now.
        WR: begin
          if (!wdata_ready) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (wdata_valid) begin
            write     <= 1'b1;
            BusMuxOut <= wdata;
            addr      <= ptr;
            ptr       <= ptr + ADDR_W'(1);
            if (remaining == '0)
              wdata_ready <= 1'b0;
            else
              remaining <= remaining - BURST_W'(1);
          end
        end

        FIN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: behavioural 512x32 RAM, event log, hand-computed expectations.
module tb_mem_master;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          done, err, read, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] BusMuxOut;
  logic [DW-1:0] MDataIn;

  int n_checks = 0;
  int n_fail   = 0;

  mem_master #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err),
    .read(read), .write(write), .addr(addr), .BusMuxOut(BusMuxOut),
    .MDataIn(MDataIn)
  );

  always #5 clock = ~clock;

  // RAM: registered read, write wins over read.
  logic [DW-1:0] ram [512];
  always @(posedge clock) begin
    if (write)
      ram[addr] <= BusMuxOut;
    else if (read)
      MDataIn <= ram[addr];
  end

  // Event log sampled on the falling edge.
  int          cyc = 0;
  int          rw_both = 0;
  int          rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$];
  int          rsp_cyc_q[$], done_cyc_q[$];
  logic [31:0] wr_data_q[$], rsp_q[$];

  always @(negedge clock) begin
    if (reset_n) begin
      cyc++;
      if (read)      begin rd_addr_q.push_back(int'(addr)); rd_cyc_q.push_back(cyc); end
      if (write)     begin wr_addr_q.push_back(int'(addr)); wr_data_q.push_back(BusMuxOut); wr_cyc_q.push_back(cyc); end
      if (rsp_valid) begin rsp_q.push_back(rsp_data); rsp_cyc_q.push_back(cyc); end
      if (done)      done_cyc_q.push_back(cyc);
      if (read && write) rw_both++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_log();
    rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete();
    wr_data_q.delete(); rsp_q.delete(); rsp_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic start_req(input logic we, input int a, input int len);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(a);
    req_len   = BW'(len);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    logic [31:0] burst_exp [3];
    int          busy_ready;
    int          n;

    burst_exp[0] = 32'h0000_ffff;
    burst_exp[1] = 32'h0000_0003;
    burst_exp[2] = 32'h0000_000a;

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < 512; i++) ram[i] = '0;
    ram[95]  = 32'h4;
    ram[100] = 32'hffff;
    ram[101] = 32'h3;
    ram[102] = 32'ha;
    ram[103] = 32'h55;
    ram[510] = 32'h510a;
    ram[511] = 32'h511b;
    ram[0]   = 32'hc0;

    // Reset state
    tick(2);
    check("rst_req_ready",   32'(req_ready),   32'd1);
    check("rst_read",        32'(read),        32'd0);
    check("rst_write",       32'(write),       32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check("rst_err",         32'(err),         32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single read, len=0
    clear_log();
    start_req(1'b0, 95, 0);
    wait_done("t1");
    check("t1_rd_cnt",   32'(rd_addr_q.size()), 32'd1);
    check("t1_rd_addr",  32'(rd_addr_q[0]), 32'd95);
    check("t1_rsp_cnt",  32'(rsp_q.size()), 32'd1);
    check("t1_rsp_data", rsp_q[0], 32'h0000_0004);
    check("t1_rsp_lat",  32'(rsp_cyc_q[0] - rd_cyc_q[0]), 32'd2);
    check("t1_done_cnt", 32'(done_cyc_q.size()), 32'd1);
    check("t1_done_lat", 32'(done_cyc_q[0] - rsp_cyc_q[0]), 32'd1);

    // Burst read, len=2
    clear_log();
    start_req(1'b0, 100, 2);
    wait_done("t2");
    check("t2_rd_cnt", 32'(rd_addr_q.size()), 32'd3);
    check("t2_rsp_cnt", 32'(rsp_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_rd_addr%0d", i), 32'(rd_addr_q[i]), 32'(100 + i));
      check($sformatf("t2_rsp%0d", i), rsp_q[i], burst_exp[i]);
    end
    check("t2_rd_contig",  32'(rd_cyc_q[2] - rd_cyc_q[0]), 32'd2);
    check("t2_rsp_contig", 32'(rsp_cyc_q[2] - rsp_cyc_q[0]), 32'd2);
    check("t2_rsp_lat",    32'(rsp_cyc_q[0] - rd_cyc_q[0]), 32'd2);
    check("t2_done_cnt",   32'(done_cyc_q.size()), 32'd1);
    check("t2_done_lat",   32'(done_cyc_q[0] - rsp_cyc_q[2]), 32'd1);

    // wdata_valid while idle must not write
    clear_log();
    wdata_valid = 1'b1; wdata = 32'hdead_beef;
    tick(3);
    wdata_valid = 1'b0;
    check("t3_idle_wr", 32'(wr_addr_q.size()), 32'd0);

    // Write burst, len=1, two-cycle gap between beats
    start_req(1'b1, 87, 1);
    wdata_valid = 1'b1; wdata = 32'h87;
    tick();
    wdata_valid = 1'b0;
    tick(2);
    wdata_valid = 1'b1; wdata = 32'h0a0a;
    tick();
    wdata_valid = 1'b0;
    wait_done("t3");
    check("t3_wr_cnt",   32'(wr_addr_q.size()), 32'd2);
    check("t3_wr_addr0", 32'(wr_addr_q[0]), 32'd87);
    check("t3_wr_addr1", 32'(wr_addr_q[1]), 32'd88);
    check("t3_wr_data0", wr_data_q[0], 32'h87);
    check("t3_wr_data1", wr_data_q[1], 32'h0a0a);
    check("t3_wr_gap",   32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd3);
    check("t3_done_lat", 32'(done_cyc_q[0] - wr_cyc_q[1]), 32'd1);
    check("t3_no_reads", 32'(rd_addr_q.size()), 32'd0);

    clear_log();
    start_req(1'b0, 87, 1);
    wait_done("t3rb");
    check("t3rb_rsp_cnt", 32'(rsp_q.size()), 32'd2);
    check("t3rb_rsp0", rsp_q[0], 32'h87);
    check("t3rb_rsp1", rsp_q[1], 32'h0a0a);

    // Wrap at the top address
    clear_log();
    start_req(1'b0, 510, 2);
    wait_done("t4");
    check("t4_done_cnt", 32'(done_cyc_q.size()), 32'd1);
`ifdef MEM_MASTER_BOUNDS_EN
    check("t4_rd_cnt",  32'(rd_addr_q.size()), 32'd0);
    check("t4_rsp_cnt", 32'(rsp_q.size()), 32'd0);
    check("t4_err",     32'(err), 32'd1);
`else
    check("t4_rd_cnt",   32'(rd_addr_q.size()), 32'd3);
    check("t4_rd_addr0", 32'(rd_addr_q[0]), 32'd510);
    check("t4_rd_addr1", 32'(rd_addr_q[1]), 32'd511);
    check("t4_rd_addr2", 32'(rd_addr_q[2]), 32'd0);
    check("t4_rsp2",     rsp_q[2], 32'hc0);
    check("t4_err",      32'(err), 32'd0);
`endif

    // req_valid held during a burst: second request waits for IDLE
    clear_log();
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(100); req_len = BW'(2);
    tick();
    req_addr = AW'(95); req_len = BW'(0);
    busy_ready = 0;
    n = 0;
    while (!done && n < 100) begin
      if (req_ready) busy_ready++;
      tick();
      n++;
    end
    check("t5_done_seen",   32'(done), 32'd1);
    check("t5_busy_ready",  32'(busy_ready), 32'd0);
    check("t5_fin_ready",   32'(req_ready), 32'd0);
    tick();
    check("t5_idle_ready",  32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("t5_accepted",    32'(req_ready), 32'd0);
    wait_done("t5b");
    check("t5_rd_cnt",   32'(rd_addr_q.size()), 32'd4);
    check("t5_rd_addr3", 32'(rd_addr_q[3]), 32'd95);
    check("t5_rsp_cnt",  32'(rsp_q.size()), 32'd4);
    check("t5_rsp3",     rsp_q[3], 32'h4);
    check("t5_done_cnt", 32'(done_cyc_q.size()), 32'd2);

    // Reset during beat 2 of a len=3 read
    clear_log();
    start_req(1'b0, 100, 3);
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_read",      32'(read), 32'd0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_done",      32'(done), 32'd0);
    check("t6_rst_ready",     32'(req_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick(6);
    check("t6_no_rsp",   32'(rsp_q.size()), 32'd0);
    check("t6_no_done",  32'(done_cyc_q.size()), 32'd0);
    check("t6_ready",    32'(req_ready), 32'd1);
    check("t6_err",      32'(err), 32'd0);
    clear_log();
    start_req(1'b0, 95, 0);
    wait_done("t6b");
    check("t6b_rsp_cnt", 32'(rsp_q.size()), 32'd1);
    check("t6b_rsp",     rsp_q[0], 32'h4);

    check("rw_exclusive", 32'(rw_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end
endmodule
